error_node: RTL and testbench

//  Terminal stage of the NoC MLP. Consumes forward flits from the last MatMul layer, subtracts a buffered target

---
 rtl/error_node_pkg.sv | 33 +++
 rtl/error_node_fifo.sv | 59 +++++
 rtl/error_node.sv | 146 ++++++++++++++
 tb/tb_error_node.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/error_node_pkg.sv
// Shared widths, flit field offsets and lane arithmetic for the error node.
package error_node_pkg;
   localparam int unsigned LANES               = 7;
   localparam int unsigned LANE_W              = 9;
   localparam int unsigned DATA_W              = LANES * LANE_W;
   localparam int unsigned FLIT_DATA_W         = 64;
   localparam int unsigned NUM_USER_RECV_PORTS = 4;
   localparam int unsigned DEST_BITS           = $clog2(NUM_USER_RECV_PORTS);
   localparam int unsigned FLIT_W              = 2 + FLIT_DATA_W + DEST_BITS + 2;
   localparam int unsigned BP_BIT              = DATA_W;
   localparam int unsigned VC_LSB              = DATA_W + 1;
   localparam int unsigned DEST_LSB            = VC_LSB + 2;
   localparam int unsigned TAIL_BIT            = DEST_LSB + DEST_BITS;
   localparam int unsigned VALID_BIT           = TAIL_BIT + 1;
   localparam int unsigned ABS_W               = LANE_W + 3;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT_TGT, ST_CALC, ST_SEND} state_e;

   // a - b at one extra bit, clamped back into the signed lane range
   function automatic logic [LANE_W-1:0] sat_sub(input logic [LANE_W-1:0] a,
                                                 input logic [LANE_W-1:0] b);
      logic [LANE_W:0] d;
      d = {a[LANE_W-1], a} - {b[LANE_W-1], b};
      if (!d[LANE_W] && d[LANE_W-1]) return {1'b0, {(LANE_W-1){1'b1}}};
      else if (d[LANE_W] && !d[LANE_W-1]) return {1'b1, {(LANE_W-1){1'b0}}};
      else return d[LANE_W-1:0];
   endfunction

   // Magnitude as unsigned, so the most negative lane maps to 2^(LANE_W-1)
   function automatic logic [LANE_W-1:0] abs_lane(input logic [LANE_W-1:0] e);
      return e[LANE_W-1] ? LANE_W'((~e) + LANE_W'(1)) : e;
   endfunction
endpackage

// File: rtl/error_node_fifo.sv
// Small synchronous FIFO holding preloaded target vectors; a push into a full
// FIFO is honoured only when a pop happens on the same edge.
module error_node_fifo #(
   parameter int unsigned WIDTH = 63,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] head_c,
   output logic             not_full,
   output logic             empty
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             not_full_q, not_full_d, empty_q, empty_d;
   logic             push, pop;

   always_comb begin
      pop        = rd_en && !empty_q;
      push       = wr_en && (not_full_q || pop);
      wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d    = count_q + CW'(push) - CW'(pop);
      not_full_d = (count_d != CW'(DEPTH));
      empty_d    = (count_d == '0);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         not_full_q <= 1'b1;
         empty_q    <= 1'b1;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         not_full_q <= not_full_d;
         empty_q    <= empty_d;
      end
   end

   // Storage needs no reset; the pointers define what is valid
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign head_c   = mem_q[rd_ptr_q];
   assign not_full = not_full_q;
   assign empty    = empty_q;
endmodule

// File: rtl/error_node.sv
// NoC MLP terminal stage: subtracts a queued target from each forward flit,
// saturates and scales the error, and returns it as a backprop flit.
module error_node
   import error_node_pkg::*;
#(
   parameter int unsigned LR_SHIFT  = 0,
   parameter int unsigned TGT_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DEST_BITS-1:0] dest_backward,
   input  logic [FLIT_W-1:0]    flit_in,
   output logic                 recv_flit,
   input  logic                 tgt_valid,
   input  logic [DATA_W-1:0]    tgt_data,
   output logic                 tgt_ready,
   output logic                 send_flit,
   output logic [FLIT_W-1:0]    flit_out,
   output logic [31:0]          err_abs_sum,
   output logic [15:0]          sample_cnt,
   output logic [7:0]           drop_cnt
);
   state_e              state_q, state_d;
   logic [DATA_W-1:0]   out_buf_q, out_buf_d, res_q, res_d;
   logic                recv_q, recv_d, send_q, send_d;
   logic [FLIT_W-1:0]   flit_q, flit_d;
   logic [31:0]         abs_sum_q, abs_sum_d;
   logic [15:0]         sample_q, sample_d;
   logic [7:0]          drop_q, drop_d;

   logic [DATA_W-1:0]   tgt_head_c, res_c;
   logic                fifo_not_full, fifo_empty, fifo_pop;
   logic                fwd_valid, fwd_bp;
   logic [ABS_W-1:0]    lane_abs_c [LANES];
   logic [ABS_W-1:0]    abs_total_c;
   logic [32:0]         abs_wide_c;
   logic [31:0]         abs_sat_c;
   logic                unused_flit_hdr;

   error_node_fifo #(.WIDTH(DATA_W), .DEPTH(TGT_DEPTH)) u_tgt_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (tgt_valid),
      .wr_data  (tgt_data),
      .rd_en    (fifo_pop),
      .head_c   (tgt_head_c),
      .not_full (fifo_not_full),
      .empty    (fifo_empty)
   );

   // Per-lane saturated error, scaled result and magnitude
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [LANE_W-1:0] err;
      assign err = sat_sub(out_buf_q[i*LANE_W +: LANE_W], tgt_head_c[i*LANE_W +: LANE_W]);
      assign res_c[i*LANE_W +: LANE_W] = LANE_W'($signed(err) >>> LR_SHIFT);
      assign lane_abs_c[i] = ABS_W'(abs_lane(err));
   end

   always_comb begin
      abs_total_c = '0;
      for (int i = 0; i < LANES; i++) abs_total_c = abs_total_c + lane_abs_c[i];
   end

   assign abs_wide_c = {1'b0, abs_sum_q} + 33'(abs_total_c);
   assign abs_sat_c  = abs_wide_c[32] ? '1 : abs_wide_c[31:0];

   // Only the valid, backprop and payload fields of an incoming flit matter here
   assign unused_flit_hdr = ^flit_in[TAIL_BIT:VC_LSB];

   always_comb begin
      state_d   = state_q;
      out_buf_d = out_buf_q;
      res_d     = res_q;
      abs_sum_d = abs_sum_q;
      sample_d  = sample_q;
      drop_d    = drop_q;
      send_d    = 1'b0;
      flit_d    = '0;
      fifo_pop  = 1'b0;
      fwd_valid = flit_in[VALID_BIT];
      fwd_bp    = flit_in[BP_BIT];

      case (state_q)
         ST_IDLE: begin
            if (fwd_valid && !fwd_bp) begin
               out_buf_d = flit_in[DATA_W-1:0];
               state_d   = fifo_empty ? ST_WAIT_TGT : ST_CALC;
            end
         end
         ST_WAIT_TGT: begin
            if (!fifo_empty) state_d = ST_CALC;
         end
         ST_CALC: begin
            fifo_pop  = 1'b1;
            res_d     = res_c;
            abs_sum_d = abs_sat_c;
            state_d   = ST_SEND;
         end
         ST_SEND: begin
            send_d   = 1'b1;
            flit_d   = {1'b1, 1'b1, dest_backward, 2'b00, 1'b1, res_q};
            sample_d = sample_q + 16'd1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Anything not consumed as a forward flit in IDLE is dropped
      if (fwd_valid && (fwd_bp || state_q != ST_IDLE) && drop_q != 8'hFF)
         drop_d = drop_q + 8'd1;

      recv_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         out_buf_q <= '0;
         res_q     <= '0;
         recv_q    <= 1'b1;
         send_q    <= 1'b0;
         flit_q    <= '0;
         abs_sum_q <= '0;
         sample_q  <= '0;
         drop_q    <= '0;
      end else begin
         state_q   <= state_d;
         out_buf_q <= out_buf_d;
         res_q     <= res_d;
         recv_q    <= recv_d;
         send_q    <= send_d;
         flit_q    <= flit_d;
         abs_sum_q <= abs_sum_d;
         sample_q  <= sample_d;
         drop_q    <= drop_d;
      end
   end

   assign recv_flit   = recv_q;
   assign tgt_ready   = fifo_not_full;
   assign send_flit   = send_q;
   assign flit_out    = flit_q;
   assign err_abs_sum = abs_sum_q;
   assign sample_cnt  = sample_q;
   assign drop_cnt    = drop_q;
endmodule

// File: tb/tb_error_node.sv
// Scoreboard bench for error_node: two instances (LR_SHIFT 0 and 2) share one
// stimulus stream and are checked against a transaction-level model.
`timescale 1ns/1ps
module tb_error_node;
   import error_node_pkg::*;

   localparam int unsigned HDR_W = FLIT_W - DATA_W - 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 reset;
   logic [DEST_BITS-1:0] dest;
   logic [FLIT_W-1:0]    flit_in;
   logic                 tgt_valid;
   logic [DATA_W-1:0]    tgt_data;

   logic recv0, rdy0, send0, recv2, rdy2, send2;
   logic [FLIT_W-1:0] fout0, fout2;
   logic [31:0] abs0, abs2;
   logic [15:0] cnt0, cnt2;
   logic [7:0]  drop0, drop2;

   error_node #(.LR_SHIFT(0), .TGT_DEPTH(4)) dut0 (
      .clk(clk), .reset(reset), .dest_backward(dest), .flit_in(flit_in), .recv_flit(recv0),
      .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(rdy0), .send_flit(send0),
      .flit_out(fout0), .err_abs_sum(abs0), .sample_cnt(cnt0), .drop_cnt(drop0));

   error_node #(.LR_SHIFT(2), .TGT_DEPTH(4)) dut2 (
      .clk(clk), .reset(reset), .dest_backward(dest), .flit_in(flit_in), .recv_flit(recv2),
      .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(rdy2), .send_flit(send2),
      .flit_out(fout2), .err_abs_sum(abs2), .sample_cnt(cnt2), .drop_cnt(drop2));

   typedef struct packed {
      logic [FLIT_W-1:0] f0;
      logic [FLIT_W-1:0] f2;
      logic [31:0]       abs;
      logic [15:0]       cnt;
   } exp_t;

   logic [DATA_W-1:0] m_tgt[$];
   logic [DATA_W-1:0] m_out[$];
   exp_t              exp_q[$];
   longint            m_abs;
   int                m_cnt, m_drop;
   bit                m_busy;
   int                checks, errors;

   task automatic chk(input string name, input logic [FLIT_W-1:0] act, input logic [FLIT_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int sx(input logic [LANE_W-1:0] v);
      return v[LANE_W-1] ? int'(v) - 512 : int'(v);
   endfunction

   function automatic int floor_div_pow2(input int e, input int k);
      int p;
      p = 1 << k;
      if (e >= 0) return e / p;
      return -((-e + p - 1) / p);
   endfunction

   function automatic logic [DATA_W-1:0] rand_vec();
      logic [DATA_W-1:0] v;
      v = '0;
      for (int i = 0; i < LANES; i++) begin
         case ($urandom_range(0, 5))
            0:       v[i*LANE_W +: LANE_W] = 9'h0FF;
            1:       v[i*LANE_W +: LANE_W] = 9'h100;
            default: v[i*LANE_W +: LANE_W] = LANE_W'($urandom);
         endcase
      end
      return v;
   endfunction

   // Pair forward samples with targets in arrival order and predict the result
   task automatic model_pair();
      logic [DATA_W-1:0] o, t;
      exp_t x;
      int e, a;
      while (m_out.size() > 0 && m_tgt.size() > 0) begin
         o = m_out.pop_front();
         t = m_tgt.pop_front();
         x = '0;
         a = 0;
         x.f0[FLIT_W-1] = 1'b1;  x.f0[FLIT_W-2] = 1'b1;
         x.f0[FLIT_W-3 -: DEST_BITS] = dest;  x.f0[DATA_W] = 1'b1;
         x.f2[FLIT_W-1] = 1'b1;  x.f2[FLIT_W-2] = 1'b1;
         x.f2[FLIT_W-3 -: DEST_BITS] = dest;  x.f2[DATA_W] = 1'b1;
         for (int i = 0; i < LANES; i++) begin
            e = sx(o[i*LANE_W +: LANE_W]) - sx(t[i*LANE_W +: LANE_W]);
            if (e > 255) e = 255;
            if (e < -256) e = -256;
            a += (e < 0) ? -e : e;
            x.f0[i*LANE_W +: LANE_W] = LANE_W'(e);
            x.f2[i*LANE_W +: LANE_W] = LANE_W'(floor_div_pow2(e, 2));
         end
         m_abs = m_abs + longint'(a);
         if (m_abs > 64'sd4294967295) m_abs = 64'sd4294967295;
         m_cnt = (m_cnt + 1) % 65536;
         x.abs = 32'(m_abs);
         x.cnt = 16'(m_cnt);
         exp_q.push_back(x);
      end
   endtask

   task automatic model_reset();
      exp_q.delete(); m_tgt.delete(); m_out.delete();
      m_abs = 0; m_cnt = 0; m_drop = 0; m_busy = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_tgt(input logic [DATA_W-1:0] t);
      tgt_valid = 1'b1;
      tgt_data  = t;
      if (m_tgt.size() < 4) begin
         m_tgt.push_back(t);
         model_pair();
      end
      tick();
      tgt_valid = 1'b0;
   endtask

   task automatic send_fwd(input logic [DATA_W-1:0] d, input bit bp);
      flit_in = '0;
      flit_in[FLIT_W-1] = 1'b1;
      flit_in[FLIT_W-2 -: HDR_W] = HDR_W'($urandom);
      flit_in[DATA_W] = bp;
      flit_in[DATA_W-1:0] = d;
      if (bp || m_busy) begin
         if (m_drop < 255) m_drop++;
      end else begin
         m_busy = 1;
         m_out.push_back(d);
         model_pair();
      end
      tick();
      flit_in = '0;
   endtask

   task automatic wait_send(output int n);
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (send0) begin
            n = i;
            break;
         end
      end
      checks++;
      if (n == 0) begin
         errors++;
         $display("FAIL wait_send actual=timeout required=send_flit within 20 cycles");
      end
      m_busy = 0;
   endtask

   // Monitor: every presented backprop flit is matched against the next prediction
   always @(negedge clk) begin : monitor
      exp_t x;
      if (reset && (send0 || send2)) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_send actual=%0h required=no flit", fout0);
         end else begin
            x = exp_q.pop_front();
            chk("flit_s0", fout0, x.f0);
            chk("flit_s2", fout2, x.f2);
            chk("abs_sum_s0", FLIT_W'(abs0), FLIT_W'(x.abs));
            chk("abs_sum_s2", FLIT_W'(abs2), FLIT_W'(x.abs));
            chk("sample_cnt_s0", FLIT_W'(cnt0), FLIT_W'(x.cnt));
            chk("sample_cnt_s2", FLIT_W'(cnt2), FLIT_W'(x.cnt));
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin : stim
      int n;
      logic [DATA_W-1:0] v, w;
      checks = 0; errors = 0;
      reset = 1'b0; flit_in = '0; tgt_valid = 1'b0; tgt_data = '0; dest = 2'd2;
      model_reset();
      tick(); tick();
      reset = 1'b1;

      chk("rst_recv", FLIT_W'(recv0), FLIT_W'(1));
      chk("rst_recv_s2", FLIT_W'(recv2), FLIT_W'(1));
      chk("rst_send", FLIT_W'(send0), FLIT_W'(0));
      chk("rst_flit", fout0, FLIT_W'(0));
      chk("rst_abs", FLIT_W'(abs0), FLIT_W'(0));
      chk("rst_cnt", FLIT_W'(cnt0), FLIT_W'(0));
      chk("rst_drop", FLIT_W'(drop0), FLIT_W'(0));
      chk("rst_tgt_ready", FLIT_W'(rdy0), FLIT_W'(1));
      chk("rst_tgt_ready_s2", FLIT_W'(rdy2), FLIT_W'(1));

      // Basic: error 5 on every lane, accepted-to-send latency of two edges
      dest = 2'd2;
      push_tgt({LANES{9'h005}});
      send_fwd({LANES{9'h00A}}, 1'b0);
      wait_send(n);
      chk("t1_latency", FLIT_W'(n), FLIT_W'(2));
      chk("t1_abs", FLIT_W'(abs0), FLIT_W'(35));
      chk("t1_cnt", FLIT_W'(cnt0), FLIT_W'(1));

      // Saturation both ways
      dest = 2'd1;
      v = '0; v[8:0] = 9'h100;
      w = '0; w[8:0] = 9'h0FF;
      push_tgt(v); send_fwd(w, 1'b0); wait_send(n);
      chk("t2_pos_sat", FLIT_W'(fout0[8:0]), FLIT_W'(9'h0FF));
      push_tgt(w); send_fwd(v, 1'b0); wait_send(n);
      chk("t2_neg_sat", FLIT_W'(fout0[8:0]), FLIT_W'(9'h100));

      // Learning-rate shift on the second instance
      v = '0; v[8:0] = 9'h009; v[17:9] = 9'h001;
      w = '0; w[8:0] = 9'h001; w[17:9] = 9'h008;
      push_tgt(v); send_fwd(w, 1'b0); wait_send(n);
      chk("t3_lane0_s2", FLIT_W'(fout2[8:0]), FLIT_W'(9'h1FE));
      chk("t3_lane1_s2", FLIT_W'(fout2[17:9]), FLIT_W'(9'h001));

      // Target arrives late
      dest = 2'd3;
      send_fwd(rand_vec(), 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_wait_recv", FLIT_W'(recv0), FLIT_W'(0));
         chk("t4_wait_send", FLIT_W'(send0), FLIT_W'(0));
      end
      push_tgt(rand_vec());
      wait_send(n);
      chk("t4_latency", FLIT_W'(n), FLIT_W'(3));

      // Drops: busy forward flit, then backprop flit in IDLE
      push_tgt(rand_vec());
      send_fwd(rand_vec(), 1'b0);
      send_fwd(rand_vec(), 1'b0);
      wait_send(n);
      send_fwd(rand_vec(), 1'b1);
      chk("t5_drop", FLIT_W'(drop0), FLIT_W'(2));
      chk("t5_drop_s2", FLIT_W'(drop2), FLIT_W'(2));

      // Randomized samples
      for (int it = 0; it < 40; it++) begin
         int mode;
         mode = int'($urandom_range(0, 5));
         dest = DEST_BITS'($urandom);
         if (mode != 0 && m_tgt.size() < 4)
            repeat ($urandom_range(1, 4 - m_tgt.size())) push_tgt(rand_vec());
         if (m_tgt.size() == 0) begin
            send_fwd(rand_vec(), 1'b0);
            repeat ($urandom_range(0, 3)) tick();
            push_tgt(rand_vec());
         end else begin
            send_fwd(rand_vec(), 1'b0);
            if (mode == 5) send_fwd(rand_vec(), 1'b0);
         end
         wait_send(n);
         if (mode == 4) send_fwd(rand_vec(), 1'b1);
         chk("rand_drop", FLIT_W'(drop0), FLIT_W'(m_drop));
      end

      // Drain, then overfill the target FIFO
      while (m_tgt.size() > 0) begin
         send_fwd(rand_vec(), 1'b0);
         wait_send(n);
      end
      for (int i = 0; i < 4; i++) push_tgt(rand_vec());
      chk("t6_full_ready", FLIT_W'(rdy0), FLIT_W'(0));
      push_tgt(rand_vec());
      for (int i = 0; i < 4; i++) begin
         send_fwd(rand_vec(), 1'b0);
         wait_send(n);
      end
      chk("t6_ready_after", FLIT_W'(rdy0), FLIT_W'(1));
      send_fwd(rand_vec(), 1'b0);
      repeat (3) tick();
      chk("t6_fifo_empty_wait", FLIT_W'(recv0), FLIT_W'(0));
      push_tgt(rand_vec());
      wait_send(n);

      // Reset while in CALC aborts the sample
      push_tgt(rand_vec());
      send_fwd(rand_vec(), 1'b0);
      reset = 1'b0;
      model_reset();
      tick();
      reset = 1'b1;
      chk("t6_rst_abs", FLIT_W'(abs0), FLIT_W'(0));
      chk("t6_rst_cnt", FLIT_W'(cnt0), FLIT_W'(0));
      chk("t6_rst_drop", FLIT_W'(drop0), FLIT_W'(0));
      chk("t6_rst_recv", FLIT_W'(recv0), FLIT_W'(1));
      chk("t6_rst_ready", FLIT_W'(rdy0), FLIT_W'(1));
      repeat (3) tick();
      chk("t6_rst_no_send", FLIT_W'(send0), FLIT_W'(0));
      send_fwd(rand_vec(), 1'b0);
      repeat (3) tick();
      chk("t6_rst_fifo_empty", FLIT_W'(recv0), FLIT_W'(0));
      push_tgt(rand_vec());
      wait_send(n);
      chk("t6_post_cnt", FLIT_W'(cnt0), FLIT_W'(1));

      repeat (5) tick();
      chk("exp_drained", FLIT_W'(exp_q.size()), FLIT_W'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
